// File: rtl/qupls_mul_pipe.sv
// rtl/qupls_mul_pipe.sv - tagged valid/ready pipelined SIMD integer multiplier
//
// Purpose:
//   Multiplies a by b per lane with a selectable signed/unsigned, low/high half result.
//   The result is carried with its tag through STAGES registers. Bubbles collapse,
//   the pipe stalls on out_ready, and flush kills everything in flight.
//
// Optional feature macro: QUPLS_MULPIPE_OVF_EN
//   If defined, ovf reports per-lane overflow of low-half ops.
//   If undefined, ovf is tied to 0 and no overflow logic is built.
//
// Parameters: WID (operand width), LANES (SIMD lanes, LW = WID/LANES), STAGES (latency), TAGW.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   flush                 clear all in-flight ops (including any op presented this cycle)
//   in_valid/in_ready     operation handshake; in_op selects MUL/MULU/MULH/MULHU
//   in_tag, a, b          tag and operands of the presented op
//   out_valid/out_ready   result handshake
//   out_tag, o, ovf       tag, lane-concatenated result, per-lane overflow
//   busy                  any stage holds a valid op
module qupls_mul_pipe #(
  parameter int WID    = 64,
  parameter int LANES  = 1,
  parameter int STAGES = 3,
  parameter int TAGW   = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [TAGW-1:0]  in_tag,
  input  logic [WID-1:0]   a,
  input  logic [WID-1:0]   b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [TAGW-1:0]  out_tag,
  output logic [WID-1:0]   o,
  output logic [LANES-1:0] ovf,
  output logic             busy
);

  localparam int LW = WID / LANES;

  // The whole product is formed at entry; the stages carry the finished result.
  logic [WID-1:0]   res_d;
`ifdef QUPLS_MULPIPE_OVF_EN
  logic [LANES-1:0] ovf_d;
`endif

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic          sgn;
    logic [2*LW-1:0] ax;
    logic [2*LW-1:0] bx;
    logic [2*LW-1:0] prod;
    logic [LW-1:0] lo;
    logic [LW-1:0] hi;

    // Ops 0/2 are signed, 1/3 unsigned; a 2LW-wide product of extended operands
    // is exact for both interpretations.
    assign sgn  = ~in_op[0];
    assign ax   = sgn ? {{LW{a[k*LW+LW-1]}}, a[k*LW +: LW]} : {{LW{1'b0}}, a[k*LW +: LW]};
    assign bx   = sgn ? {{LW{b[k*LW+LW-1]}}, b[k*LW +: LW]} : {{LW{1'b0}}, b[k*LW +: LW]};
    assign prod = ax * bx;
    assign lo   = prod[LW-1:0];
    assign hi   = prod[2*LW-1:LW];
    assign res_d[k*LW +: LW] = in_op[1] ? hi : lo;

`ifdef QUPLS_MULPIPE_OVF_EN
    // A low-half result overflows when the discarded upper half is not just an
    // extension of the returned lower half.
    assign ovf_d[k] = ~in_op[1] & (sgn ? (hi != {LW{lo[LW-1]}}) : (hi != '0));
`endif
  end

  logic [STAGES-1:0] v;
  logic [STAGES-1:0] ld;
  logic              all_full;
  logic [TAGW-1:0]   tag_q [STAGES];
  logic [WID-1:0]    dat_q [STAGES];
`ifdef QUPLS_MULPIPE_OVF_EN
  logic [LANES-1:0]  ovf_q [STAGES];
`endif

  // Stage s can take new contents when the output drains or any stage from s
  // onward is empty, so bubbles collapse toward the output.
  always_comb begin
    ld       = '0;
    all_full = 1'b1;
    for (int s = STAGES - 1; s >= 0; s--) begin
      all_full = all_full & v[s];
      ld[s]    = out_ready | ~all_full;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v <= '0;
      for (int s = 0; s < STAGES; s++) begin
        tag_q[s] <= '0;
        dat_q[s] <= '0;
`ifdef QUPLS_MULPIPE_OVF_EN
        ovf_q[s] <= '0;
`endif
      end
    end else begin
      if (flush) begin
        v <= '0;
      end else begin
        if (ld[0]) v[0] <= in_valid;
        for (int s = 1; s < STAGES; s++) begin
          if (ld[s]) v[s] <= v[s-1];
        end
      end
      // Payload only moves with a valid op; stale payload behind a clear valid is harmless.
      if (ld[0] && in_valid) begin
        tag_q[0] <= in_tag;
        dat_q[0] <= res_d;
`ifdef QUPLS_MULPIPE_OVF_EN
        ovf_q[0] <= ovf_d;
`endif
      end
      for (int s = 1; s < STAGES; s++) begin
        if (ld[s] && v[s-1]) begin
          tag_q[s] <= tag_q[s-1];
          dat_q[s] <= dat_q[s-1];
`ifdef QUPLS_MULPIPE_OVF_EN
          ovf_q[s] <= ovf_q[s-1];
`endif
        end
      end
    end
  end

  assign in_ready  = ~rst & ld[0];
  assign out_valid = v[STAGES-1];
  assign out_tag   = tag_q[STAGES-1];
  assign o         = dat_q[STAGES-1];
  assign busy      = |v;
`ifdef QUPLS_MULPIPE_OVF_EN
  assign ovf       = ovf_q[STAGES-1];
`else
  assign ovf       = '0;
`endif

endmodule

// File: tb/tb_qupls_mul_pipe.sv
// tb/tb_qupls_mul_pipe.sv - self-checking bench for qupls_mul_pipe
module tb_qupls_mul_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, flush, in_valid, out_ready;
  logic [1:0]  in_op;
  logic [5:0]  in_tag;
  logic [63:0] a, b;

  logic        in_ready1, out_valid1, busy1;
  logic [5:0]  out_tag1;
  logic [63:0] o1;
  logic [0:0]  ovf1;
  logic        in_ready4, out_valid4, busy4;
  logic [5:0]  out_tag4;
  logic [63:0] o4;
  logic [3:0]  ovf4;

`ifdef QUPLS_MULPIPE_OVF_EN
  localparam bit OVF_ON = 1'b1;
`else
  localparam bit OVF_ON = 1'b0;
`endif

  qupls_mul_pipe #(.WID(64), .LANES(1), .STAGES(3), .TAGW(6)) dut1 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready1),
    .in_op(in_op), .in_tag(in_tag), .a(a), .b(b), .out_valid(out_valid1),
    .out_ready(out_ready), .out_tag(out_tag1), .o(o1), .ovf(ovf1), .busy(busy1));

  qupls_mul_pipe #(.WID(64), .LANES(4), .STAGES(3), .TAGW(6)) dut4 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready4),
    .in_op(in_op), .in_tag(in_tag), .a(a), .b(b), .out_valid(out_valid4),
    .out_ready(out_ready), .out_tag(out_tag4), .o(o4), .ovf(ovf4), .busy(busy4));

  int checks = 0;
  int passed = 0;

  typedef struct {
    logic [5:0]  tag;
    logic [63:0] o;
    logic [3:0]  ovf;
  } exp_t;

  exp_t q1[$];
  exp_t q4[$];

  // Reference: each lane is read as an integer (two's complement or unsigned),
  // multiplied exactly, and the requested half taken; overflow means the exact
  // product is outside the representable range of one lane.
  function automatic exp_t mk(input int lanes, input logic [1:0] op,
                              input logic [63:0] x, input logic [63:0] y, input logic [5:0] tag);
    exp_t e;
    int lw;
    logic [63:0] mask, xl, yl, part;
    logic signed [129:0] xa, ya, p, lim, hs;
    lw = 64 / lanes;
    mask = '1;
    if (lw < 64) mask = (64'd1 << lw) - 64'd1;
    lim = 130'sd1 <<< lw;
    e.tag = tag; e.o = '0; e.ovf = '0;
    for (int k = 0; k < lanes; k++) begin
      xl = (x >> (k * lw)) & mask;
      yl = (y >> (k * lw)) & mask;
      xa = $signed({66'd0, xl});
      ya = $signed({66'd0, yl});
      if (!op[0]) begin
        if (xl[lw-1]) xa = xa - lim;
        if (yl[lw-1]) ya = ya - lim;
      end
      p = xa * ya;
      hs = p >>> lw;
      part = op[1] ? (hs[63:0] & mask) : (p[63:0] & mask);
      e.o = e.o | (part << (k * lw));
      if (!op[1]) begin
        if (!op[0]) e.ovf[k] = (p < -(lim >>> 1)) || (p >= (lim >>> 1));
        else        e.ovf[k] = (p >= lim);
      end
    end
    if (!OVF_ON) e.ovf = '0;
    return e;
  endfunction

  function automatic logic [63:0] pick();
    case ($urandom_range(0, 7))
      0: return 64'd0;
      1: return 64'd1;
      2: return '1;
      3: return 64'h8000_0000_0000_0000;
      4: return 64'h7FFF_FFFF_FFFF_FFFF;
      5: return 64'h8000_7FFF_FFFF_0001;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b1; in_op = 2'd0; in_tag = 6'd5;
    a = 64'd7; b = 64'd9; out_ready = 1'b1;
    tick(); tick(); #1;
    checks++; if (out_valid1 !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid1); else passed++;
    checks++; if (o1 !== 64'd0) $display("FAIL reset_o got %h want 0", o1); else passed++;
    checks++; if (out_tag1 !== 6'd0) $display("FAIL reset_tag got %h want 0", out_tag1); else passed++;
    checks++; if (ovf1 !== 1'b0) $display("FAIL reset_ovf got %b want 0", ovf1); else passed++;
    checks++; if (busy1 !== 1'b0) $display("FAIL reset_busy got %b want 0", busy1); else passed++;
    checks++; if (in_ready1 !== 1'b0) $display("FAIL reset_in_ready got %b want 0", in_ready1); else passed++;
    checks++; if (o4 !== 64'd0 || out_valid4 !== 1'b0) $display("FAIL reset_lane4 got o=%h v=%b want 0/0", o4, out_valid4); else passed++;
    rst = 1'b0; in_valid = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    tick();
    in_valid = 1'b1; in_op = 2'd0; a = 64'hFFFF_FFFF_FFFF_FFFD; b = 64'd5; in_tag = 6'd9; out_ready = 1'b1;
    #1;
    checks++; if (in_ready1 !== 1'b1) $display("FAIL basic_in_ready got %b want 1", in_ready1); else passed++;
    tick();
    in_valid = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      #1;
      checks++;
      if (out_valid1 !== (k == 3)) $display("FAIL basic_latency cycle %0d got %b want %b", k, out_valid1, (k == 3));
      else passed++;
      if (k < 3) tick();
    end
    checks++; if (o1 !== 64'hFFFF_FFFF_FFFF_FFF1) $display("FAIL basic_o got %h want fffffffffffffff1", o1); else passed++;
    checks++; if (out_tag1 !== 6'd9) $display("FAIL basic_tag got %0d want 9", out_tag1); else passed++;
    checks++; if (ovf1 !== 1'b0) $display("FAIL basic_ovf got %b want 0", ovf1); else passed++;
  endtask

  task automatic test_high();
    exp_t e4;
    tick();
    in_valid = 1'b1; in_op = 2'd3; a = 64'h8000_0000_0000_0000; b = 64'd4; in_tag = 6'd1; out_ready = 1'b1;
    tick();
    in_op = 2'd2; in_tag = 6'd2;
    tick();
    in_valid = 1'b0;
    tick(); #1;
    e4 = mk(4, 2'd3, 64'h8000_0000_0000_0000, 64'd4, 6'd1);
    checks++; if (out_valid1 !== 1'b1 || out_tag1 !== 6'd1 || o1 !== 64'd2)
      $display("FAIL mulhu got v=%b tag=%0d o=%h want 1/1/2", out_valid1, out_tag1, o1); else passed++;
    checks++; if (o4 !== e4.o) $display("FAIL mulhu_lanes got %h want %h", o4, e4.o); else passed++;
    tick(); #1;
    e4 = mk(4, 2'd2, 64'h8000_0000_0000_0000, 64'd4, 6'd2);
    checks++; if (out_valid1 !== 1'b1 || out_tag1 !== 6'd2 || o1 !== 64'hFFFF_FFFF_FFFF_FFFE)
      $display("FAIL mulh got v=%b tag=%0d o=%h want 1/2/fffffffffffffffe", out_valid1, out_tag1, o1); else passed++;
    checks++; if (o4 !== e4.o) $display("FAIL mulh_lanes got %h want %h", o4, e4.o); else passed++;
  endtask

  task automatic test_lanes();
    exp_t e4;
    tick();
    in_valid = 1'b1; in_op = 2'd1; a = 64'h0002_FFFF_0003_0100; b = 64'h0003_0002_0005_0100;
    in_tag = 6'd3; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick(); #1;
    e4 = mk(4, 2'd1, 64'h0002_FFFF_0003_0100, 64'h0003_0002_0005_0100, 6'd3);
    checks++; if (out_valid4 !== 1'b1 || o4 !== 64'h0006_FFFE_000F_0000)
      $display("FAIL lanes_o got v=%b o=%h want 1/0006fffe000f0000", out_valid4, o4); else passed++;
    checks++; if (o4 !== e4.o) $display("FAIL lanes_model got %h want %h", o4, e4.o); else passed++;
    checks++; if (ovf4 !== (OVF_ON ? 4'b0101 : 4'b0000))
      $display("FAIL lanes_ovf got %b want %b", ovf4, (OVF_ON ? 4'b0101 : 4'b0000)); else passed++;
  endtask

  task automatic test_back_to_back();
    int idx, got, first_out, last_out, acc_at_low;
    bit saw_low;
    exp_t e;
    idx = 0; got = 0; first_out = -1; last_out = -1; acc_at_low = -1; saw_low = 0;
    q1.delete();
    tick();
    for (int cyc = 0; cyc < 40 && got < 6; cyc++) begin
      in_valid = (idx < 6);
      if (idx < 6) begin
        in_op = 2'($urandom_range(0, 3)); a = pick(); b = pick(); in_tag = 6'(idx + 1);
      end
      out_ready = (cyc >= 8);
      #1;
      if (cyc < 8 && !in_ready1 && !saw_low) begin saw_low = 1; acc_at_low = idx; end
      if (cyc == 7) begin
        checks++; if (idx !== 3) $display("FAIL b2b_stall_accepted got %0d want 3", idx); else passed++;
        checks++; if (out_valid1 !== 1'b1 || out_tag1 !== 6'd1 || o1 !== q1[0].o)
          $display("FAIL b2b_stall_hold got v=%b tag=%0d o=%h want 1/1/%h", out_valid1, out_tag1, o1, q1[0].o); else passed++;
      end
      if (out_valid1 && out_ready) begin
        if (first_out < 0) first_out = cyc;
        last_out = cyc;
        e = q1.pop_front();
        got++;
        checks++; if (out_tag1 !== e.tag || o1 !== e.o)
          $display("FAIL b2b_result got tag=%0d o=%h want tag=%0d o=%h", out_tag1, o1, e.tag, e.o); else passed++;
      end
      if (in_valid && in_ready1) begin
        q1.push_back(mk(1, in_op, a, b, in_tag));
        idx++;
      end
      tick();
    end
    in_valid = 1'b0;
    checks++; if (acc_at_low !== 3) $display("FAIL b2b_in_ready_fall got %0d want 3", acc_at_low); else passed++;
    checks++; if (got !== 6) $display("FAIL b2b_count got %0d want 6", got); else passed++;
    checks++; if (last_out - first_out !== 5) $display("FAIL b2b_gaps got span %0d want 5", last_out - first_out); else passed++;
  endtask

  task automatic test_flush();
    int seen;
    seen = 0;
    tick();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_op = 2'd0; a = pick(); b = pick(); in_tag = 6'(10 + i);
      tick();
    end
    in_tag = 6'd63; flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    #1;
    checks++; if (out_valid1 !== 1'b0) $display("FAIL flush_out_valid got %b want 0", out_valid1); else passed++;
    checks++; if (busy1 !== 1'b0 || busy4 !== 1'b0) $display("FAIL flush_busy got %b/%b want 0/0", busy1, busy4); else passed++;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (out_valid1) seen++;
      tick();
    end
    checks++; if (seen !== 0) $display("FAIL flush_leak got %0d results want 0", seen); else passed++;
  endtask

  task automatic test_reset_mid();
    tick();
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_op = 2'd1; a = 64'd3; b = 64'd3; in_tag = 6'(30 + i);
      tick();
    end
    in_valid = 1'b0; rst = 1'b1;
    tick();
    in_valid = 1'b1; #1;
    checks++; if (out_valid1 !== 1'b0 || o1 !== 64'd0) $display("FAIL rstmid_out got v=%b o=%h want 0/0", out_valid1, o1); else passed++;
    checks++; if (in_ready1 !== 1'b0) $display("FAIL rstmid_in_ready got %b want 0", in_ready1); else passed++;
    tick();
    rst = 1'b0; out_ready = 1'b1; in_valid = 1'b1; in_op = 2'd1; a = 64'd7; b = 64'd6; in_tag = 6'd21;
    #1;
    checks++; if (in_ready1 !== 1'b1) $display("FAIL rstmid_ready_after got %b want 1", in_ready1); else passed++;
    tick();
    in_valid = 1'b0;
    tick(); tick(); #1;
    checks++; if (out_valid1 !== 1'b1 || out_tag1 !== 6'd21 || o1 !== 64'd42)
      $display("FAIL rstmid_new_op got v=%b tag=%0d o=%h want 1/21/42", out_valid1, out_tag1, o1); else passed++;
  endtask

  task automatic test_random();
    exp_t e;
    q1.delete(); q4.delete();
    tick();
    for (int cyc = 0; cyc < 600; cyc++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      in_op = 2'($urandom_range(0, 3)); a = pick(); b = pick(); in_tag = 6'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 49) == 0);
      #1;
      if (out_valid1 && out_ready) begin
        if (q1.size() == 0) begin
          checks++; $display("FAIL rand1_unexpected got tag=%0d want none", out_tag1);
        end else begin
          e = q1.pop_front();
          checks++; if (out_tag1 !== e.tag || o1 !== e.o || ovf1 !== e.ovf[0])
            $display("FAIL rand1 got tag=%0d o=%h ovf=%b want tag=%0d o=%h ovf=%b", out_tag1, o1, ovf1, e.tag, e.o, e.ovf[0]);
          else passed++;
        end
      end
      if (out_valid4 && out_ready) begin
        if (q4.size() == 0) begin
          checks++; $display("FAIL rand4_unexpected got tag=%0d want none", out_tag4);
        end else begin
          e = q4.pop_front();
          checks++; if (out_tag4 !== e.tag || o4 !== e.o || ovf4 !== e.ovf)
            $display("FAIL rand4 got tag=%0d o=%h ovf=%b want tag=%0d o=%h ovf=%b", out_tag4, o4, ovf4, e.tag, e.o, e.ovf);
          else passed++;
        end
      end
      if (flush) begin
        q1.delete(); q4.delete();
      end else begin
        if (in_valid && in_ready1) q1.push_back(mk(1, in_op, a, b, in_tag));
        if (in_valid && in_ready4) q4.push_back(mk(4, in_op, a, b, in_tag));
      end
      tick();
    end
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    for (int cyc = 0; cyc < 20; cyc++) begin
      #1;
      if (out_valid1 && q1.size() != 0) begin
        e = q1.pop_front();
        checks++; if (out_tag1 !== e.tag || o1 !== e.o) $display("FAIL drain1 got tag=%0d o=%h want tag=%0d o=%h", out_tag1, o1, e.tag, e.o); else passed++;
      end
      if (out_valid4 && q4.size() != 0) begin
        e = q4.pop_front();
        checks++; if (out_tag4 !== e.tag || o4 !== e.o) $display("FAIL drain4 got tag=%0d o=%h want tag=%0d o=%h", out_tag4, o4, e.tag, e.o); else passed++;
      end
      tick();
    end
    checks++; if (q1.size() != 0 || q4.size() != 0)
      $display("FAIL rand_leftover got %0d/%0d pending want 0/0", q1.size(), q4.size()); else passed++;
    checks++; if (busy1 !== 1'b0 || busy4 !== 1'b0) $display("FAIL rand_idle_busy got %b/%b want 0/0", busy1, busy4); else passed++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_high();
    test_lanes();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
